cond_flag_unit: RTL and testbench
=================================

# cond_flag_unit

- Condition-evaluation and flag-commit stage of the ARMv4 execute path. Registered as a single-entry pipeline stage.
- Per instruction, it evaluates the 4-bit condition field against the current NZCV flags, with forwarding from the instruction it is committing.
- It drives the WRITE/WRITE_DATA inputs of the four one-bit NZCV flag registers downstream and reads their outputs back.
- It also keeps saturating counts of executed and squashed instructions.

## Interface

Parameters:
- CNT_W, 16, width of EXEC_CNT and SQUASH_CNT

Ports:
- CLK  in  1  clock; all state updates on falling edge
- RST  in  1  asynchronous, active-low reset
- IN_VALID  in  1  upstream instruction valid
- IN_READY  out  1  stage can accept
- COND  in  4  ARM condition field [31:28]
- S_BIT  in  1  instruction requests flag update
- FLAG_MASK  in  4  {N,Z,C,V} bits this instruction may update
- ALU_FLAGS  in  4  {N,Z,C,V} produced by the ALU for this instruction
- FLAGS_IN  in  4  {N,Z,C,V} READ_DATA of the four flag registers
- OUT_VALID  out  1  stage holds an instruction
- OUT_READY  in  1  downstream accepts
- EXEC  out  1  held instruction passed its condition
- FLAG_WE  out  4  per-flag WRITE to the flag registers
- FLAG_WD  out  4  per-flag WRITE_DATA to the flag registers
- EXEC_CNT  out  CNT_W  instructions leaving with EXEC=1, saturating
- SQUASH_CNT  out  CNT_W  instructions leaving with EXEC=0, saturating

## Operation

Handshake:
- IN_READY = !OUT_VALID | OUT_READY (combinational).
- Capture on a falling edge when IN_VALID & IN_READY.
- Leave on a falling edge when OUT_VALID & OUT_READY. Capture and leave may occur on the same edge.
- If an instruction leaves and none is captured, OUT_VALID clears.

Registered contents:
- EXEC, S_BIT, FLAG_MASK and ALU_FLAGS are registered at capture.
- EXEC is computed at capture time from the effective flags F.

Effective flags F, per bit i:
- F[i] = FLAG_WD[i] when FLAG_WE[i] is asserted on the same edge (forwarding from the leaving instruction).
- Otherwise F[i] = FLAGS_IN[i].

Condition table (0000–1111):
- EQ: Z | NE: !Z | CS: C | CC: !C
- MI: N | PL: !N | VS: V | VC: !V
- HI: C&!Z | LS: !C|Z | GE: N==V | LT: N!=V
- GT: !Z&(N==V) | LE: Z|(N!=V) | AL: 1 | 1111: 0 (NV, never)

Flag write, combinational:
- FLAG_WE = {4{OUT_VALID & OUT_READY & EXEC & S_BIT_r}} & FLAG_MASK_r.
- FLAG_WD = ALU_FLAGS_r.
- A squashed instruction never writes flags.

Counters:
- On each leave, increment EXEC_CNT if EXEC=1, else SQUASH_CNT.
- Both hold at 2^CNT_W−1.

Reset state:
- OUT_VALID=0, EXEC=0, FLAG_WE=0000.
- FLAG_WD=0000 (registered ALU_FLAGS=0).
- EXEC_CNT=0, SQUASH_CNT=0.
- IN_READY=1 while reset is asserted.
- The flag registers reset to 1, so FLAGS_IN=1111 after reset.

## Timing

Latency:
- One falling edge from capture to OUT_VALID.
- A flag written on edge k is visible on FLAGS_IN after edge k.
- The instruction captured on edge k sees it through forwarding, so there are no stall cycles between a flag-setting instruction and a dependent one.

Backpressure:
- While OUT_VALID=1 and OUT_READY=0: all outputs hold, FLAG_WE=0000, IN_READY=0, counters hold.

Reset mid-operation:
- The held instruction is dropped. No FLAG_WE is produced for it and it is not counted.
- Deassertion takes effect on the next falling edge.

## Test plan

1. **Reset then condition checks.** Release RST with FLAGS_IN=1111, OUT_READY=1, then send COND=0000 followed by COND=0001. Required: EXEC=1 then EXEC=0; EXEC_CNT=1, SQUASH_CNT=1.
2. **Back-to-back forwarding.** Send A (COND=1110, S=1, MASK=1111, ALU_FLAGS=0100), then on the next edge B (COND=0000) while FLAGS_IN still reads 1011. Required: A drives FLAG_WE=1111, FLAG_WD=0100; B captures EXEC=1.
3. **Squashed S-instruction.** With FLAGS_IN=0000, send COND=0100, S=1, MASK=1111, ALU_FLAGS=1111. Required: EXEC=0, FLAG_WE=0000 when it leaves, SQUASH_CNT increments.
4. **Backpressure.** Hold OUT_READY=0 for 3 edges with IN_VALID=1. Required: IN_READY=0, outputs stable, FLAG_WE=0000. On release, exactly one leave occurs and the next instruction is captured on the same edge.
5. **Full sweep and partial mask.** Sweep all 16 COND values against all 16 FLAGS_IN values and compare EXEC with the table. Then send MASK=1100. Required: only N and Z write enables assert.
6. **Saturation and reset mid-op.** With CNT_W=4, send 20 squashed instructions. Required: SQUASH_CNT=15. Then assert RST while OUT_VALID=1. Required: OUT_VALID=0, both counters 0, no FLAG_WE pulse.

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: a single-entry execute stage. It evaluates the ARM condition
// field against the NZCV flags (forwarding the flags written by the instruction
// leaving the stage), drives the flag register writes, and counts executed and
// squashed instructions with saturating counters. All state changes on the
// falling edge of CLK.
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       COND,
  input  logic             S_BIT,
  input  logic [3:0]       FLAG_MASK,
  input  logic [3:0]       ALU_FLAGS,
  input  logic [3:0]       FLAGS_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             EXEC,
  output logic [3:0]       FLAG_WE,
  output logic [3:0]       FLAG_WD,
  output logic [CNT_W-1:0] EXEC_CNT,
  output logic [CNT_W-1:0] SQUASH_CNT
);

  // Handshake: an instruction is captured on a falling edge when
  // IN_VALID & IN_READY, and leaves on a falling edge when OUT_VALID & OUT_READY.
  // IN_READY = !OUT_VALID | OUT_READY, so a capture and a leave may share an edge.
  // The one-bit occupancy register (valid_r) is the only control state and is
  // visible directly on OUT_VALID.

  logic       valid_r;
  logic       exec_r;
  logic       s_bit_r;
  logic [3:0] mask_r;
  logic [3:0] alu_r;
  logic       capture;
  logic       leave;
  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       eff_n, eff_z, eff_c, eff_v;

  assign leave    = valid_r & OUT_READY;
  assign IN_READY = ~valid_r | OUT_READY;
  assign capture  = IN_VALID & IN_READY;

  assign OUT_VALID = valid_r;
  assign EXEC      = exec_r;

  // A squashed or stalled instruction never writes flags.
  assign FLAG_WE = {4{leave & exec_r & s_bit_r}} & mask_r;
  assign FLAG_WD = alu_r;

  // Forward the bits written by the leaving instruction; the flag registers
  // only show them after this edge.
  assign eff_flags = (FLAG_WE & FLAG_WD) | (~FLAG_WE & FLAGS_IN);
  assign eff_n = eff_flags[3];
  assign eff_z = eff_flags[2];
  assign eff_c = eff_flags[1];
  assign eff_v = eff_flags[0];

  // Condition-field evaluation against the effective flags.
  always_comb begin
    cond_pass = 1'b0;
    case (COND)
      4'b0000: cond_pass = eff_z;
      4'b0001: cond_pass = ~eff_z;
      4'b0010: cond_pass = eff_c;
      4'b0011: cond_pass = ~eff_c;
      4'b0100: cond_pass = eff_n;
      4'b0101: cond_pass = ~eff_n;
      4'b0110: cond_pass = eff_v;
      4'b0111: cond_pass = ~eff_v;
      4'b1000: cond_pass = eff_c & ~eff_z;
      4'b1001: cond_pass = ~eff_c | eff_z;
      4'b1010: cond_pass = (eff_n == eff_v);
      4'b1011: cond_pass = (eff_n != eff_v);
      4'b1100: cond_pass = ~eff_z & (eff_n == eff_v);
      4'b1101: cond_pass = eff_z | (eff_n != eff_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Stage occupancy: set on capture, cleared when the held entry leaves alone.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      valid_r <= 1'b0;
    end else if (capture) begin
      valid_r <= 1'b1;
    end else if (leave) begin
      valid_r <= 1'b0;
    end
  end

  // Instruction payload, loaded only on capture so it holds under backpressure.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      exec_r  <= 1'b0;
      s_bit_r <= 1'b0;
      mask_r  <= 4'b0000;
      alu_r   <= 4'b0000;
    end else if (capture) begin
      exec_r  <= cond_pass;
      s_bit_r <= S_BIT;
      mask_r  <= FLAG_MASK;
      alu_r   <= ALU_FLAGS;
    end
  end

  // Saturating counts of leaving instructions, split by their EXEC result.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      EXEC_CNT   <= '0;
      SQUASH_CNT <= '0;
    end else if (leave) begin
      if (exec_r) begin
        if (EXEC_CNT != {CNT_W{1'b1}}) EXEC_CNT <= EXEC_CNT + 1'b1;
      end else begin
        if (SQUASH_CNT != {CNT_W{1'b1}}) SQUASH_CNT <= SQUASH_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Testbench for cond_flag_unit: directed instruction stream, expected leave
// records queued at capture, and a monitor that checks every leave and stall.
module tb_cond_flag_unit;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [3:0]       COND;
  logic             S_BIT;
  logic [3:0]       FLAG_MASK;
  logic [3:0]       ALU_FLAGS;
  logic [3:0]       FLAGS_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             EXEC;
  logic [3:0]       FLAG_WE;
  logic [3:0]       FLAG_WD;
  logic [CNT_W-1:0] EXEC_CNT;
  logic [CNT_W-1:0] SQUASH_CNT;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .COND(COND), .S_BIT(S_BIT), .FLAG_MASK(FLAG_MASK), .ALU_FLAGS(ALU_FLAGS),
    .FLAGS_IN(FLAGS_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .EXEC(EXEC), .FLAG_WE(FLAG_WE), .FLAG_WD(FLAG_WD),
    .EXEC_CNT(EXEC_CNT), .SQUASH_CNT(SQUASH_CNT)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Expected leave record: {exec, flag_we[3:0], flag_wd[3:0]}
  logic [8:0] exp_q[$];
  int unsigned mdl_exec_cnt = 0;
  int unsigned mdl_squash_cnt = 0;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference condition evaluation built from the ARM encoding structure:
  // bits [3:1] pick a base test, bit 0 inverts it (1111 therefore never passes).
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] c, input logic s, input logic [3:0] m,
                      input logic [3:0] a, input logic [3:0] fl, input logic e);
    int waited;
    waited = 0;
    @(posedge CLK); #1;
    IN_VALID = 1'b1; COND = c; S_BIT = s; FLAG_MASK = m; ALU_FLAGS = a; FLAGS_IN = fl;
    #1;
    while (!IN_READY && waited < 20) begin
      @(posedge CLK); #2;
      waited++;
    end
    check("send_ready", 32'(IN_READY), 32'(1'b1));
    if (IN_READY) exp_q.push_back({e, ((e && s) ? m : 4'b0000), a});
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int waited;
    idle();
    waited = 0;
    @(posedge CLK); #3;
    while (OUT_VALID && waited < 20) begin
      @(posedge CLK); #3;
      waited++;
    end
    check("drain_done", 32'(OUT_VALID), 32'(1'b0));
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    mdl_exec_cnt = 0;
    mdl_squash_cnt = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic       prev_stall;
    logic       prev_exec;
    logic [3:0] prev_wd;
    logic [CNT_W-1:0] prev_ec, prev_sc;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_exec = 1'b0; prev_wd = 4'b0; prev_ec = '0; prev_sc = '0;
    forever begin
      @(posedge CLK); #3;
      if (!RST) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_exec_hold", 32'(EXEC), 32'(prev_exec));
          check("stall_wd_hold", 32'(FLAG_WD), 32'(prev_wd));
          check("stall_exec_cnt_hold", 32'(EXEC_CNT), 32'(prev_ec));
          check("stall_squash_cnt_hold", 32'(SQUASH_CNT), 32'(prev_sc));
        end
        if (OUT_VALID && OUT_READY) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL leave_unexpected: actual=leave required=none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("leave_exec", 32'(EXEC), 32'(e[8]));
            check("leave_flag_we", 32'(FLAG_WE), 32'(e[7:4]));
            check("leave_flag_wd", 32'(FLAG_WD), 32'(e[3:0]));
            check("leave_exec_cnt", 32'(EXEC_CNT), mdl_exec_cnt);
            check("leave_squash_cnt", 32'(SQUASH_CNT), mdl_squash_cnt);
            if (e[8]) begin
              if (mdl_exec_cnt < CNT_MAX) mdl_exec_cnt++;
            end else begin
              if (mdl_squash_cnt < CNT_MAX) mdl_squash_cnt++;
            end
          end
        end else begin
          check("idle_flag_we", 32'(FLAG_WE), 32'(4'b0000));
          if (OUT_VALID) check("stall_in_ready", 32'(IN_READY), 32'(1'b0));
        end
        prev_stall = OUT_VALID && !OUT_READY;
        prev_exec = EXEC; prev_wd = FLAG_WD; prev_ec = EXEC_CNT; prev_sc = SQUASH_CNT;
      end
    end
  end

  // Watchdog: the run must end on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    RST = 1'b0; IN_VALID = 1'b0; COND = 4'b0; S_BIT = 1'b0; FLAG_MASK = 4'b0;
    ALU_FLAGS = 4'b0; FLAGS_IN = 4'b1111; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #3;
    check("rst_out_valid", 32'(OUT_VALID), 32'(1'b0));
    check("rst_exec", 32'(EXEC), 32'(1'b0));
    check("rst_flag_we", 32'(FLAG_WE), 32'(4'b0000));
    check("rst_flag_wd", 32'(FLAG_WD), 32'(4'b0000));
    check("rst_exec_cnt", 32'(EXEC_CNT), 32'(0));
    check("rst_squash_cnt", 32'(SQUASH_CNT), 32'(0));
    check("rst_in_ready", 32'(IN_READY), 32'(1'b1));
    @(posedge CLK); #1;
    RST = 1'b1;

    // 1: EQ passes, NE squashes with flags 1111
    send(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    send(4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    drain();
    check("t1_exec_cnt", 32'(EXEC_CNT), 32'(1));
    check("t1_squash_cnt", 32'(SQUASH_CNT), 32'(1));

    // 2: A writes Z=1; B (EQ) sees it through forwarding although FLAGS_IN has Z=0
    send(4'b1110, 1'b1, 4'b1111, 4'b0100, 4'b1011, 1'b1);
    send(4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1011, 1'b1);
    drain();
    check("t2_exec_cnt", 32'(EXEC_CNT), 32'(3));

    // 3: MI with N=0 squashes; its S-bit write must not happen
    send(4'b0100, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    drain();
    check("t3_squash_cnt", 32'(SQUASH_CNT), 32'(2));

    // 4: backpressure for 3 edges; Q (NE, FLAGS_IN Z=1) sees P's forwarded Z=0
    send(4'b1110, 1'b1, 4'b1111, 4'b1010, 4'b0100, 1'b1);
    fork
      send(4'b0001, 1'b0, 4'b0000, 4'b0011, 4'b0100, 1'b1);
      begin
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    drain();
    check("t4_exec_cnt", 32'(EXEC_CNT), 32'(5));

    // 5: full condition sweep (no flag writes), then a partial mask write
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        send(4'(c), 1'b0, 4'b0000, 4'(f), 4'(f), ref_cond(4'(c), 4'(f)));
      end
    end
    send(4'b1110, 1'b1, 4'b1100, 4'b1111, 4'b0000, 1'b1);
    drain();

    // 6: saturation of the squash counter, then reset while an entry is held
    apply_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int i = 0; i < 20; i++) send(4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    drain();
    check("t6_squash_sat", 32'(SQUASH_CNT), 32'(15));
    check("t6_exec_zero", 32'(EXEC_CNT), 32'(0));
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    send(4'b1110, 1'b1, 4'b1111, 4'b0101, 4'b1111, 1'b1);
    idle();
    #2;
    check("t6_held", 32'(OUT_VALID), 32'(1'b1));
    apply_reset();
    #1;
    check("t6_rst_out_valid", 32'(OUT_VALID), 32'(1'b0));
    check("t6_rst_exec_cnt", 32'(EXEC_CNT), 32'(0));
    check("t6_rst_squash_cnt", 32'(SQUASH_CNT), 32'(0));
    OUT_READY = 1'b1;
    #1;
    check("t6_rst_flag_we", 32'(FLAG_WE), 32'(4'b0000));
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #3;
    check("t6_post_out_valid", 32'(OUT_VALID), 32'(1'b0));
    check("t6_post_flag_we", 32'(FLAG_WE), 32'(4'b0000));
    check("t6_post_squash_cnt", 32'(SQUASH_CNT), 32'(0));
    check("t6_post_exec_cnt", 32'(EXEC_CNT), 32'(0));
    repeat (2) @(posedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
